// File: rtl/al_accel_cfg_pkg.sv
// rtl/al_accel_cfg_pkg.sv - shared widths, commit FSM encoding and register index map for the config bank
package al_accel_cfg_pkg;

    localparam int CFG_DATA_W   = 32;
    localparam int CFG_SEL_W    = 4;
    localparam int CFG_NUM_REGS = 11;

    localparam logic [1:0] COMMIT_IDLE = 2'd0;
    localparam logic [1:0] COMMIT_WAIT = 2'd1;
    localparam logic [1:0] COMMIT_COPY = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = COMMIT_IDLE,
        ST_WAIT = COMMIT_WAIT,
        ST_COPY = COMMIT_COPY
    } commit_state_t;

    // Accelerator register slots within the bank
    localparam int REG_CTRL     = 0;
    localparam int REG_MODE     = 1;
    localparam int REG_SRC_ADDR = 2;
    localparam int REG_DST_ADDR = 3;
    localparam int REG_LEN      = 4;
    localparam int REG_STRIDE   = 5;
    localparam int REG_TILE_W   = 6;
    localparam int REG_TILE_H   = 7;
    localparam int REG_SCALE    = 8;
    localparam int REG_BIAS     = 9;
    localparam int REG_IRQ_MASK = 10;

endpackage

// File: rtl/al_accel_config_bank_if.sv
// rtl/al_accel_config_bank_if.sv - host config bus; read-back signals exist only with AL_ACCEL_CFG_READBACK_EN
interface al_accel_config_bank_if
    import al_accel_cfg_pkg::*;
#(
    parameter int DATA_W = CFG_DATA_W,
    parameter int SEL_W  = CFG_SEL_W
);
    logic                  config_wen;
    logic [SEL_W-1:0]      config_sel;
    logic [DATA_W-1:0]     config_data;
    logic [DATA_W/8-1:0]   config_be;
`ifdef AL_ACCEL_CFG_READBACK_EN
    logic                  config_ren;
    logic                  config_rsrc;
    logic [DATA_W-1:0]     config_rdata;
    logic                  config_rvalid;

    modport master (
        output config_wen, config_sel, config_data, config_be, config_ren, config_rsrc,
        input  config_rdata, config_rvalid
    );
    modport slave (
        input  config_wen, config_sel, config_data, config_be, config_ren, config_rsrc,
        output config_rdata, config_rvalid
    );
`else
    modport master (
        output config_wen, config_sel, config_data, config_be
    );
    modport slave (
        input  config_wen, config_sel, config_data, config_be
    );
`endif
endinterface

// File: rtl/al_accel_cfg_reg.sv
// rtl/al_accel_cfg_reg.sv - one shadow/active register pair with byte-enable writes and a copy strobe
module al_accel_cfg_reg
    import al_accel_cfg_pkg::*;
#(
    parameter int DATA_W = CFG_DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wen_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic                copy_i,
    output logic [DATA_W-1:0]   shadow_o,
    output logic [DATA_W-1:0]   active_o
);
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [DATA_W-1:0] active_q, active_d;

    always_comb begin
        shadow_d = shadow_q;
        for (int b = 0; b < DATA_W/8; b++) begin
            if (wen_i && be_i[b]) begin
                shadow_d[b*8 +: 8] = wdata_i[b*8 +: 8];
            end
        end
        // The copy takes the registered shadow, so a same-cycle write reaches only the shadow
        active_d = copy_i ? shadow_q : active_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign shadow_o = shadow_q;
    assign active_o = active_q;
endmodule

// File: rtl/al_accel_config_bank.sv
// rtl/al_accel_config_bank.sv - double-buffered config bank with idle-gated commit; read-back under AL_ACCEL_CFG_READBACK_EN
module al_accel_config_bank
    import al_accel_cfg_pkg::*;
#(
    parameter int DATA_W   = CFG_DATA_W,
    parameter int NUM_REGS = CFG_NUM_REGS,
    parameter int SEL_W    = CFG_SEL_W
) (
    input  logic                       clk,
    input  logic                       reset,
    al_accel_config_bank_if.slave      cfg_bus,
    input  logic                       commit_req,
    input  logic                       accel_busy,
    output logic                       commit_pending,
    output logic                       commit_done,
    output logic [NUM_REGS*DATA_W-1:0] cfg_active,
    output logic                       cfg_err,
    input  logic                       err_clr
);
    localparam logic [SEL_W:0] NUM_REGS_W = (SEL_W+1)'(NUM_REGS);

    logic                       sel_in_range;
    logic                       copy_en;
    logic                       bad_access;
    logic [NUM_REGS*DATA_W-1:0] shadow_flat;
    commit_state_t              state_q, state_d;
    logic                       err_q, err_d;

    assign sel_in_range = ({1'b0, cfg_bus.config_sel} < NUM_REGS_W);

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        logic reg_wen;
        assign reg_wen = cfg_bus.config_wen && sel_in_range && (cfg_bus.config_sel == SEL_W'(i));

        al_accel_cfg_reg #(.DATA_W(DATA_W)) u_reg (
            .clk      (clk),
            .reset    (reset),
            .wen_i    (reg_wen),
            .be_i     (cfg_bus.config_be),
            .wdata_i  (cfg_bus.config_data),
            .copy_i   (copy_en),
            .shadow_o (shadow_flat[i*DATA_W +: DATA_W]),
            .active_o (cfg_active[i*DATA_W +: DATA_W])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Requests arriving while waiting simply merge into the one pending commit
    always_comb begin
        state_d        = state_q;
        commit_pending = 1'b0;
        commit_done    = 1'b0;
        copy_en        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (commit_req) begin
                    state_d = accel_busy ? ST_WAIT : ST_COPY;
                end
            end
            ST_WAIT: begin
                commit_pending = 1'b1;
                if (!accel_busy) begin
                    state_d = ST_COPY;
                end
            end
            ST_COPY: begin
                commit_done = 1'b1;
                copy_en     = 1'b1;
                state_d     = commit_req ? ST_WAIT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef AL_ACCEL_CFG_READBACK_EN
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q;

    assign bad_access = (cfg_bus.config_wen || cfg_bus.config_ren) && !sel_in_range;

    // An unmatched select leaves the mux at zero, which is the out-of-range read value
    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cfg_bus.config_sel == SEL_W'(i)) begin
                rdata_d = cfg_bus.config_rsrc ? cfg_active[i*DATA_W +: DATA_W]
                                              : shadow_flat[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= cfg_bus.config_ren;
            if (cfg_bus.config_ren) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign cfg_bus.config_rdata  = rdata_q;
    assign cfg_bus.config_rvalid = rvalid_q;
`else
    assign bad_access = cfg_bus.config_wen && !sel_in_range;
`endif

    // A new error outranks a clear in the same cycle
    always_comb begin
        err_d = err_q;
        if (bad_access) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign cfg_err = err_q;
endmodule
